// File: rtl/hazard_unit_if.sv
// Decode-flag / hazard-control bundle between the D-stage decoder and hazard_unit.
// The decoder drives the master side; hazard_unit consumes the slave side.
interface hazard_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       D_rs;
  logic [4:0]       D_rt;
  logic [4:0]       D_A3;
  logic             D_calc_r;
  logic             D_calc_i;
  logic             D_load;
  logic             D_store;
  logic             D_branch;
  logic             D_jal;
  logic             D_jr;
  logic             D_lui;
  logic             stall;
  logic [1:0]       fwd_D_rs;
  logic [1:0]       fwd_D_rt;
  logic [1:0]       fwd_E_rs;
  logic [1:0]       fwd_E_rt;
  logic             fwd_M_rt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output D_rs, D_rt, D_A3, D_calc_r, D_calc_i, D_load, D_store,
           D_branch, D_jal, D_jr, D_lui,
    input  stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_A3, D_calc_r, D_calc_i, D_load, D_store,
           D_branch, D_jal, D_jr, D_lui,
    output stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, stall_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Tuse/Tnew hazard unit for the 5-stage MIPS core: stall generation, D/E/M
// forwarding selects and a saturating stall-cycle counter.
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  hazard_unit_if.slave hz
);

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] tnew;
  } rec_t;

  rec_t       r_e, r_m, r_w;
  rec_t       w_d_rec;
  logic [1:0] w_tuse_rs, w_tuse_rt;
  logic       w_stall;
  logic [CNT_W-1:0] r_cnt;

  function automatic logic hit(input logic [4:0] src, input logic [4:0] a3);
    return (src != 5'd0) && (src == a3);
  endfunction

  function automatic rec_t age(input rec_t r);
    rec_t o;
    o = r;
    o.tnew = (r.tnew == 2'd0) ? 2'd0 : r.tnew - 2'd1;
    return o;
  endfunction

  // Tuse of 3 means "operand not read", so it can never be below any Tnew.
  always_comb begin
    w_tuse_rs = 2'd3;
    if (hz.D_branch || hz.D_jr)
      w_tuse_rs = 2'd0;
    else if (hz.D_calc_r || hz.D_calc_i || hz.D_load || hz.D_store)
      w_tuse_rs = 2'd1;

    w_tuse_rt = 2'd3;
    if (hz.D_branch)
      w_tuse_rt = 2'd0;
    else if (hz.D_calc_r)
      w_tuse_rt = 2'd1;
    else if (hz.D_store)
      w_tuse_rt = 2'd2;

    w_d_rec.rs   = hz.D_rs;
    w_d_rec.rt   = hz.D_rt;
    w_d_rec.a3   = '0;
    w_d_rec.tnew = 2'd0;
    if (hz.D_calc_r || hz.D_calc_i || hz.D_lui) begin
      w_d_rec.a3   = hz.D_A3;
      w_d_rec.tnew = 2'd1;
    end else if (hz.D_load) begin
      w_d_rec.a3   = hz.D_A3;
      w_d_rec.tnew = 2'd2;
    end else if (hz.D_jal) begin
      w_d_rec.a3   = hz.D_A3;
    end
  end

  always_comb begin
    w_stall = (hit(hz.D_rs, r_e.a3) && (w_tuse_rs < r_e.tnew)) ||
              (hit(hz.D_rs, r_m.a3) && (w_tuse_rs < r_m.tnew)) ||
              (hit(hz.D_rt, r_e.a3) && (w_tuse_rt < r_e.tnew)) ||
              (hit(hz.D_rt, r_m.a3) && (w_tuse_rt < r_m.tnew));
  end

  always_comb begin
    hz.fwd_D_rs = 2'b00;
    if (hit(hz.D_rs, r_e.a3) && (r_e.tnew == 2'd0))
      hz.fwd_D_rs = 2'b01;
    else if (hit(hz.D_rs, r_m.a3) && (r_m.tnew == 2'd0))
      hz.fwd_D_rs = 2'b10;

    hz.fwd_D_rt = 2'b00;
    if (hit(hz.D_rt, r_e.a3) && (r_e.tnew == 2'd0))
      hz.fwd_D_rt = 2'b01;
    else if (hit(hz.D_rt, r_m.a3) && (r_m.tnew == 2'd0))
      hz.fwd_D_rt = 2'b10;

    hz.fwd_E_rs = 2'b00;
    if (hit(r_e.rs, r_m.a3) && (r_m.tnew == 2'd0))
      hz.fwd_E_rs = 2'b01;
    else if (hit(r_e.rs, r_w.a3))
      hz.fwd_E_rs = 2'b10;

    hz.fwd_E_rt = 2'b00;
    if (hit(r_e.rt, r_m.a3) && (r_m.tnew == 2'd0))
      hz.fwd_E_rt = 2'b01;
    else if (hit(r_e.rt, r_w.a3))
      hz.fwd_E_rt = 2'b10;

    hz.fwd_M_rt = hit(r_m.rt, r_w.a3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e   <= '0;
      r_m   <= '0;
      r_w   <= '0;
      r_cnt <= '0;
    end else begin
      r_e <= w_stall ? rec_t'('0) : w_d_rec;
      r_m <= age(r_e);
      r_w <= age(r_m);
      if (w_stall && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign hz.stall     = w_stall;
  assign hz.stall_cnt = r_cnt;

endmodule
